// File: rtl/ara_pkg.sv
// Shared operand-queue types and sizing limits.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ara_pkg;

    // Upper bounds for the per-queue data and command storage.
    localparam int unsigned MaxOpqDepth    = 16;
    localparam int unsigned MaxOpqCmdDepth = 4;

    // Width of the element count carried by a command.
    localparam int unsigned OpqCntWidth = 16;

    // One command: how many operand words it delivers to the consumer.
    typedef struct packed {
        logic [OpqCntWidth-1:0] count;
    } opq_cmd_t;

endpackage

// File: rtl/operand_queue_slice.sv
// One operand queue: credit-tracked VRF words released to the consumer under command counts.
// Latency: a returned word reaches operand_o one cycle after it arrives, never combinationally.
// Backpressure: credits bound VRF reads; consumer valid/ready; cmd_ready low when command FIFO full.
module operand_queue_slice
    import ara_pkg::*;
#(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned Depth     = 4,
    parameter int unsigned CmdDepth  = 2,
    parameter int unsigned CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DataWidth-1:0] operand_i,
    input  logic                 operand_valid_i,
    input  logic                 operand_issued_i,
    output logic                 operand_queue_ready_o,
    input  logic [CntWidth-1:0]  cmd_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 flush_i,
    output logic [DataWidth-1:0] operand_o,
    output logic                 operand_valid_o,
    input  logic                 operand_ready_i,
    output logic                 cmd_done_o,
    output logic [31:0]          stall_cnt_o
);

    // Credit counters are sized for the largest legal depth.
    localparam int unsigned OccW  = $clog2(MaxOpqDepth + 1);
    localparam int unsigned SumW  = OccW + 2;
    localparam int unsigned DCntW = $clog2(Depth + 1);
    localparam int unsigned CCntW = $clog2(CmdDepth + 1);
    localparam int unsigned CmdW  = $bits(opq_cmd_t);

    logic [OccW-1:0]     outstanding_q;
    logic [OccW-1:0]     outstanding_d;
    logic [OccW-1:0]     discard_q;
    logic [OccW-1:0]     discard_d;
    logic [CntWidth-1:0] consumed_q;
    logic [CntWidth-1:0] consumed_d;

    logic [DCntW-1:0]    data_count;
    logic [CCntW-1:0]    cmd_count;
    logic                data_empty;
    logic                data_push;
    logic                cmd_push;
    logic                cmd_head_vld;
    opq_cmd_t            cmd_in;
    opq_cmd_t            cmd_head;
    logic [CntWidth-1:0] remaining;
    logic [SumW-1:0]     credit_use;
    logic                handshake;
    logic                last_word;
    logic                zero_retire;
    logic                cmd_retire;

    // Words arriving while discard is pending, or during a flush, are dropped.
    assign data_push = operand_valid_i && (discard_q == '0) && !flush_i;

    opq_fifo #(
        .Width (DataWidth),
        .Depth (Depth)
    ) i_data_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .flush_i  (flush_i),
        .push_i   (data_push),
        .push_dat (operand_i),
        .pop_i    (handshake),
        .head_dat (operand_o),
        .count_o  (data_count)
    );

    // A command accepted in the flush cycle survives the flush.
    assign cmd_in.count = cmd_i;
    assign cmd_ready_o  = (cmd_count != CCntW'(CmdDepth));
    assign cmd_push     = cmd_valid_i && cmd_ready_o;

    opq_fifo #(
        .Width (CmdW),
        .Depth (CmdDepth)
    ) i_cmd_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .flush_i  (flush_i),
        .push_i   (cmd_push),
        .push_dat (cmd_in),
        .pop_i    (cmd_retire),
        .head_dat (cmd_head),
        .count_o  (cmd_count)
    );

    assign data_empty   = (data_count == '0);
    assign cmd_head_vld = (cmd_count != '0);
    assign remaining    = cmd_head.count - consumed_q;

    // Flush masks the consumer side so it can never complete a command.
    assign operand_valid_o = !data_empty && cmd_head_vld && (remaining != '0) && !flush_i;
    assign handshake       = operand_valid_o && operand_ready_i;
    assign last_word       = handshake && (remaining == CntWidth'(1));
    assign zero_retire     = cmd_head_vld && (cmd_head.count == '0) && !flush_i;
    assign cmd_retire      = last_word || zero_retire;
    assign cmd_done_o      = cmd_retire;

    // Credit check uses only registered occupancy, in-flight and discard counts.
    assign credit_use = SumW'(data_count) + SumW'(outstanding_q) + SumW'(discard_q);
    assign operand_queue_ready_o = (credit_use < SumW'(Depth));

    // In-flight and discard accounting; flush turns all in-flight reads into discards.
    always_comb begin
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if (flush_i) begin
            outstanding_d = '0;
            discard_d     = OccW'(SumW'(discard_q) + SumW'(outstanding_q)
                                  + SumW'(operand_issued_i) - SumW'(operand_valid_i));
        end else if (operand_valid_i && (discard_q != '0)) begin
            discard_d     = discard_q - OccW'(1);
            outstanding_d = outstanding_q + OccW'(operand_issued_i);
        end else begin
            outstanding_d = outstanding_q + OccW'(operand_issued_i) - OccW'(operand_valid_i);
        end
    end

    // Words consumed from the head command; restarts when it retires or on flush.
    always_comb begin
        consumed_d = consumed_q;
        if (flush_i || cmd_retire) begin
            consumed_d = '0;
        end else if (handshake) begin
            consumed_d = consumed_q + CntWidth'(1);
        end
    end

    // Register the credit and command-progress state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
            discard_q     <= '0;
            consumed_q    <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            consumed_q    <= consumed_d;
        end
    end

`ifdef OPQ_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of cycles the consumer holds off a valid word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (operand_valid_o && !operand_ready_i && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

    // A VRF word with no read in flight and nothing to discard is a requester bug.
    a_no_unsolicited_word : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        operand_valid_i |-> ((outstanding_q != '0) || (discard_q != '0))
    );

endmodule

// File: rtl/opq_fifo.sv
// Generic synchronous FIFO with flush; wraps modulo Depth (any Depth >= 1).
// Latency: a pushed entry is visible at the head one cycle later (no bypass).
// Backpressure: push on full only succeeds alongside a pop; pop on empty is ignored.
module opq_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] push_dat,
    input  logic             pop_i,
    output logic [Width-1:0] head_dat,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW-1:0]  wr_idx;
    logic [CntW-1:0]  count_q;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full    = (count_q == CntW'(Depth));
    assign empty   = (count_q == '0);
    // A flush discards the head, so a pop in that cycle is meaningless.
    assign do_pop  = pop_i && !empty && !flush_i;
    // Flush frees the whole array, so a push in the flush cycle always fits.
    assign do_push = push_i && (!full || do_pop || flush_i);
    assign wr_idx  = flush_i ? '0 : wr_ptr_q;

    assign count_o  = count_q;
    assign head_dat = empty ? '0 : mem_q[rd_ptr_q];

    // Storage array; contents need no reset because count gates the head.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_idx] <= push_dat;
        end
    end

    // Pointer and occupancy bookkeeping; flush restarts from slot 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= do_push ? ptr_inc('0) : '0;
            count_q  <= do_push ? CntW'(1) : '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

endmodule

// File: rtl/operand_queue_array.sv
// Array of NrQueues independent operand queues; optional stall counters via OPQ_STALL_CNT_EN.
// Latency: one cycle from VRF word to operand_o per queue.
// Backpressure: per-queue credits to the requester, valid/ready to the consumer, cmd_ready per queue.
module operand_queue_array #(
    parameter int unsigned NrQueues  = 9,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned Depth     = 4,
    parameter int unsigned CmdDepth  = 2,
    parameter int unsigned CntWidth  = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NrQueues-1:0][DataWidth-1:0]  operand_i,
    input  logic [NrQueues-1:0]                 operand_valid_i,
    input  logic [NrQueues-1:0]                 operand_issued_i,
    output logic [NrQueues-1:0]                 operand_queue_ready_o,
    input  logic [NrQueues-1:0][CntWidth-1:0]   cmd_i,
    input  logic [NrQueues-1:0]                 cmd_valid_i,
    output logic [NrQueues-1:0]                 cmd_ready_o,
    input  logic [NrQueues-1:0]                 flush_i,
    output logic [NrQueues-1:0][DataWidth-1:0]  operand_o,
    output logic [NrQueues-1:0]                 operand_valid_o,
    input  logic [NrQueues-1:0]                 operand_ready_i,
    output logic [NrQueues-1:0]                 cmd_done_o,
    output logic [NrQueues-1:0][31:0]           stall_cnt_o
);

    for (genvar q = 0; q < NrQueues; q++) begin : gen_queue
        operand_queue_slice #(
            .DataWidth (DataWidth),
            .Depth     (Depth),
            .CmdDepth  (CmdDepth),
            .CntWidth  (CntWidth)
        ) i_slice (
            .clk_i                 (clk_i),
            .rst_ni                (rst_ni),
            .operand_i             (operand_i[q]),
            .operand_valid_i       (operand_valid_i[q]),
            .operand_issued_i      (operand_issued_i[q]),
            .operand_queue_ready_o (operand_queue_ready_o[q]),
            .cmd_i                 (cmd_i[q]),
            .cmd_valid_i           (cmd_valid_i[q]),
            .cmd_ready_o           (cmd_ready_o[q]),
            .flush_i               (flush_i[q]),
            .operand_o             (operand_o[q]),
            .operand_valid_o       (operand_valid_o[q]),
            .operand_ready_i       (operand_ready_i[q]),
            .cmd_done_o            (cmd_done_o[q]),
            .stall_cnt_o           (stall_cnt_o[q])
        );
    end

endmodule

// File: tb/tb_operand_queue_array.sv
// Directed bench for operand_queue_array with default parameters.
// Latency: inputs driven at the falling edge, outputs sampled shortly after.
// Backpressure: consumer ready driven per scenario.
module tb_operand_queue_array;

    localparam int NQ = 9;
    localparam int DW = 64;
    localparam int CW = 16;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic [NQ-1:0][DW-1:0]  operand_i;
    logic [NQ-1:0]          operand_valid_i;
    logic [NQ-1:0]          operand_issued_i;
    logic [NQ-1:0]          operand_queue_ready_o;
    logic [NQ-1:0][CW-1:0]  cmd_i;
    logic [NQ-1:0]          cmd_valid_i;
    logic [NQ-1:0]          cmd_ready_o;
    logic [NQ-1:0]          flush_i;
    logic [NQ-1:0][DW-1:0]  operand_o;
    logic [NQ-1:0]          operand_valid_o;
    logic [NQ-1:0]          operand_ready_i;
    logic [NQ-1:0]          cmd_done_o;
    logic [NQ-1:0][31:0]    stall_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    operand_queue_array dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .operand_i             (operand_i),
        .operand_valid_i       (operand_valid_i),
        .operand_issued_i      (operand_issued_i),
        .operand_queue_ready_o (operand_queue_ready_o),
        .cmd_i                 (cmd_i),
        .cmd_valid_i           (cmd_valid_i),
        .cmd_ready_o           (cmd_ready_o),
        .flush_i               (flush_i),
        .operand_o             (operand_o),
        .operand_valid_o       (operand_valid_o),
        .operand_ready_i       (operand_ready_i),
        .cmd_done_o            (cmd_done_o),
        .stall_cnt_o           (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic idle();
        operand_i        = '0;
        operand_valid_i  = '0;
        operand_issued_i = '0;
        cmd_i            = '0;
        cmd_valid_i      = '0;
        flush_i          = '0;
        operand_ready_i  = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic issue0(input int n);
        for (int i = 0; i < n; i++) begin
            operand_issued_i[0] = 1'b1;
            tick();
        end
        operand_issued_i[0] = 1'b0;
    endtask

    task automatic test_reset();
        // reset asserted at time 0, no clock edge yet
        #3;
        n_cmp++; if (operand_valid_o !== '0) begin n_bad++; $display("FAIL rst_valid got %0h want 0", operand_valid_o); end
        n_cmp++; if (operand_o !== '0) begin n_bad++; $display("FAIL rst_operand got %0h want 0", operand_o); end
        n_cmp++; if (cmd_done_o !== '0) begin n_bad++; $display("FAIL rst_done got %0h want 0", cmd_done_o); end
        n_cmp++; if (operand_queue_ready_o !== {NQ{1'b1}}) begin n_bad++; $display("FAIL rst_credit got %0h want 1ff", operand_queue_ready_o); end
        n_cmp++; if (cmd_ready_o !== {NQ{1'b1}}) begin n_bad++; $display("FAIL rst_cmd_ready got %0h want 1ff", cmd_ready_o); end
        n_cmp++; if (stall_cnt_o !== '0) begin n_bad++; $display("FAIL rst_stall got %0h want 0", stall_cnt_o); end
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_credit();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (operand_queue_ready_o[0] !== 1'b1) begin n_bad++; $display("FAIL credit_pre%0d got %b want 1", i, operand_queue_ready_o[0]); end
            operand_issued_i[0] = 1'b1;
            tick();
        end
        operand_issued_i[0] = 1'b0;
        #1;
        n_cmp++; if (operand_queue_ready_o[0] !== 1'b0) begin n_bad++; $display("FAIL credit_exhausted got %b want 0", operand_queue_ready_o[0]); end
        n_cmp++; if (operand_queue_ready_o[1] !== 1'b1) begin n_bad++; $display("FAIL credit_independent got %b want 1", operand_queue_ready_o[1]); end
        operand_valid_i[0] = 1'b1;
        operand_i[0]       = 64'h0000_00A5_0000_00A5;
        cmd_valid_i[0]     = 1'b1;
        cmd_i[0]           = 16'd1;
        tick();
        operand_valid_i[0] = 1'b0;
        cmd_valid_i[0]     = 1'b0;
        #1;
        n_cmp++; if (operand_queue_ready_o[0] !== 1'b0) begin n_bad++; $display("FAIL credit_after_return got %b want 0", operand_queue_ready_o[0]); end
        n_cmp++; if (operand_o[0] !== 64'h0000_00A5_0000_00A5) begin n_bad++; $display("FAIL credit_word got %0h want a5000000a5", operand_o[0]); end
        operand_ready_i[0] = 1'b1;
        #1;
        n_cmp++; if (cmd_done_o[0] !== 1'b1) begin n_bad++; $display("FAIL credit_done got %b want 1", cmd_done_o[0]); end
        tick();
        operand_ready_i[0] = 1'b0;
        #1;
        n_cmp++; if (operand_queue_ready_o[0] !== 1'b1) begin n_bad++; $display("FAIL credit_after_pop got %b want 1", operand_queue_ready_o[0]); end
    endtask

    task automatic test_cmd_stream();
        do_reset();
        issue0(3);
        operand_valid_i[0] = 1'b1;
        operand_i[0]       = 64'hAAAA;
        cmd_valid_i[0]     = 1'b1;
        cmd_i[0]           = 16'd3;
        #1;
        n_cmp++; if (operand_valid_o[0] !== 1'b0) begin n_bad++; $display("FAIL stream_no_bypass got %b want 0", operand_valid_o[0]); end
        tick();
        cmd_valid_i[0] = 1'b0;
        operand_i[0]   = 64'hBBBB;
        #1;
        n_cmp++; if (operand_valid_o[0] !== 1'b1 || operand_o[0] !== 64'hAAAA) begin n_bad++; $display("FAIL stream_latency got %b/%0h want 1/aaaa", operand_valid_o[0], operand_o[0]); end
        tick();
        operand_i[0] = 64'hCCCC;
        tick();
        operand_valid_i[0] = 1'b0;
        operand_ready_i[0] = 1'b1;
        #1;
        n_cmp++; if (operand_o[0] !== 64'hAAAA || cmd_done_o[0] !== 1'b0) begin n_bad++; $display("FAIL stream_a got %0h/%b want aaaa/0", operand_o[0], cmd_done_o[0]); end
        tick();
        #1;
        n_cmp++; if (operand_valid_o[0] !== 1'b1 || operand_o[0] !== 64'hBBBB || cmd_done_o[0] !== 1'b0) begin n_bad++; $display("FAIL stream_b got %b/%0h/%b want 1/bbbb/0", operand_valid_o[0], operand_o[0], cmd_done_o[0]); end
        tick();
        #1;
        n_cmp++; if (operand_valid_o[0] !== 1'b1 || operand_o[0] !== 64'hCCCC || cmd_done_o[0] !== 1'b1) begin n_bad++; $display("FAIL stream_c got %b/%0h/%b want 1/cccc/1", operand_valid_o[0], operand_o[0], cmd_done_o[0]); end
        tick();
        #1;
        n_cmp++; if (operand_valid_o[0] !== 1'b0 || cmd_done_o[0] !== 1'b0) begin n_bad++; $display("FAIL stream_end got %b/%b want 0/0", operand_valid_o[0], cmd_done_o[0]); end
        operand_ready_i[0] = 1'b0;
    endtask

    task automatic test_zero_cmd();
        int dones = 0;
        int pops = 0;
        logic [DW-1:0] got = '0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            idle();
            if (i == 0) begin
                cmd_valid_i[0]      = 1'b1;
                cmd_i[0]            = 16'd0;
                operand_issued_i[0] = 1'b1;
            end else if (i == 1) begin
                cmd_valid_i[0]     = 1'b1;
                cmd_i[0]           = 16'd1;
                operand_valid_i[0] = 1'b1;
                operand_i[0]       = 64'hD00D;
            end else begin
                operand_ready_i[0] = 1'b1;
            end
            #1;
            if (cmd_done_o[0] === 1'b1) dones++;
            if (operand_valid_o[0] === 1'b1 && operand_ready_i[0] === 1'b1) begin
                pops++;
                got = operand_o[0];
            end
            tick();
        end
        idle();
        n_cmp++; if (dones !== 2) begin n_bad++; $display("FAIL zero_cmd_dones got %0d want 2", dones); end
        n_cmp++; if (pops !== 1) begin n_bad++; $display("FAIL zero_cmd_pops got %0d want 1", pops); end
        n_cmp++; if (got !== 64'hD00D) begin n_bad++; $display("FAIL zero_cmd_word got %0h want d00d", got); end
    endtask

    task automatic test_flush();
        do_reset();
        issue0(3);
        operand_valid_i[0] = 1'b1;
        operand_i[0]       = 64'h1111;
        cmd_valid_i[0]     = 1'b1;
        cmd_i[0]           = 16'd2;
        tick();
        idle();
        #1;
        n_cmp++; if (operand_valid_o[0] !== 1'b1) begin n_bad++; $display("FAIL flush_pre_valid got %b want 1", operand_valid_o[0]); end
        flush_i[0]         = 1'b1;
        cmd_valid_i[0]     = 1'b1;
        cmd_i[0]           = 16'd1;
        operand_ready_i[0] = 1'b1;
        #1;
        n_cmp++; if (operand_valid_o[0] !== 1'b0 || cmd_done_o[0] !== 1'b0) begin n_bad++; $display("FAIL flush_cycle got %b/%b want 0/0", operand_valid_o[0], cmd_done_o[0]); end
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            operand_valid_i[0] = 1'b1;
            operand_i[0]       = 64'hBAD0 + 64'(i);
            #1;
            n_cmp++; if (operand_valid_o[0] !== 1'b0 || cmd_done_o[0] !== 1'b0) begin n_bad++; $display("FAIL flush_drop%0d got %b/%b want 0/0", i, operand_valid_o[0], cmd_done_o[0]); end
            tick();
        end
        operand_valid_i[0] = 1'b0;
        #1;
        n_cmp++; if (operand_valid_o[0] !== 1'b0) begin n_bad++; $display("FAIL flush_after_drop got %b want 0", operand_valid_o[0]); end
        n_cmp++; if (operand_queue_ready_o[0] !== 1'b1) begin n_bad++; $display("FAIL flush_credit got %b want 1", operand_queue_ready_o[0]); end
        issue0(1);
        operand_valid_i[0] = 1'b1;
        operand_i[0]       = 64'hEEEE;
        tick();
        operand_valid_i[0] = 1'b0;
        #1;
        n_cmp++; if (operand_valid_o[0] !== 1'b1 || operand_o[0] !== 64'hEEEE) begin n_bad++; $display("FAIL flush_next_word got %b/%0h want 1/eeee", operand_valid_o[0], operand_o[0]); end
        operand_ready_i[0] = 1'b1;
        #1;
        n_cmp++; if (cmd_done_o[0] !== 1'b1) begin n_bad++; $display("FAIL flush_kept_cmd got %b want 1", cmd_done_o[0]); end
        tick();
        idle();
    endtask

    task automatic test_cmd_full();
        int dones = 0;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            cmd_valid_i[0] = 1'b1;
            cmd_i[0]       = 16'd1;
            tick();
        end
        cmd_valid_i[0] = 1'b0;
        #1;
        n_cmp++; if (cmd_ready_o[0] !== 1'b0) begin n_bad++; $display("FAIL cmd_full got %b want 0", cmd_ready_o[0]); end
        issue0(2);
        for (int i = 0; i < 6; i++) begin
            operand_valid_i[0] = (i < 2);
            operand_i[0]       = 64'h5000 + 64'(i);
            operand_ready_i[0] = 1'b1;
            #1;
            if (cmd_done_o[0] === 1'b1) dones++;
            tick();
        end
        idle();
        #1;
        n_cmp++; if (dones !== 2) begin n_bad++; $display("FAIL cmd_full_dones got %0d want 2", dones); end
        n_cmp++; if (cmd_ready_o[0] !== 1'b1) begin n_bad++; $display("FAIL cmd_full_drained got %b want 1", cmd_ready_o[0]); end
    endtask

    task automatic test_stall();
        logic [31:0] exp_stall;
`ifdef OPQ_STALL_CNT_EN
        exp_stall = 32'd10;
`else
        exp_stall = 32'd0;
`endif
        do_reset();
        issue0(1);
        operand_valid_i[0] = 1'b1;
        operand_i[0]       = 64'h7777;
        cmd_valid_i[0]     = 1'b1;
        cmd_i[0]           = 16'd1;
        tick();
        idle();
        #1;
        n_cmp++; if (operand_valid_o[0] !== 1'b1 || stall_cnt_o[0] !== 32'd0) begin n_bad++; $display("FAIL stall_start got %b/%0d want 1/0", operand_valid_o[0], stall_cnt_o[0]); end
        for (int i = 0; i < 10; i++) tick();
        operand_ready_i[0] = 1'b1;
        #1;
        n_cmp++; if (stall_cnt_o[0] !== exp_stall) begin n_bad++; $display("FAIL stall_count got %0d want %0d", stall_cnt_o[0], exp_stall); end
        tick();
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue0(3);
        operand_valid_i[0] = 1'b1;
        operand_i[0]       = 64'h0A;
        cmd_valid_i[0]     = 1'b1;
        cmd_i[0]           = 16'd3;
        tick();
        cmd_valid_i[0] = 1'b0;
        operand_i[0]   = 64'h0B;
        tick();
        operand_i[0] = 64'h0C;
        tick();
        operand_valid_i[0] = 1'b0;
        operand_ready_i[0] = 1'b1;
        tick();
        operand_ready_i[0] = 1'b0;
        tick();
        tick();
        #1;
        n_cmp++; if (operand_valid_o[0] !== 1'b1 || operand_o[0] !== 64'h0B) begin n_bad++; $display("FAIL mid_pre got %b/%0h want 1/b", operand_valid_o[0], operand_o[0]); end
        #1;
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (operand_valid_o !== '0 || operand_o !== '0) begin n_bad++; $display("FAIL mid_rst_data got %0h/%0h want 0/0", operand_valid_o, operand_o); end
        n_cmp++; if (operand_queue_ready_o !== {NQ{1'b1}} || cmd_ready_o !== {NQ{1'b1}}) begin n_bad++; $display("FAIL mid_rst_ready got %0h/%0h want 1ff/1ff", operand_queue_ready_o, cmd_ready_o); end
        n_cmp++; if (cmd_done_o !== '0 || stall_cnt_o !== '0) begin n_bad++; $display("FAIL mid_rst_misc got %0h/%0h want 0/0", cmd_done_o, stall_cnt_o); end
        tick();
        rst_ni = 1'b1;
        tick();
        #1;
        n_cmp++; if (operand_valid_o[0] !== 1'b0) begin n_bad++; $display("FAIL mid_after_rst got %b want 0", operand_valid_o[0]); end
    endtask

    initial begin
        rst_ni = 1'b0;
        idle();
        test_reset();
        test_credit();
        test_cmd_stream();
        test_zero_cmd();
        test_flush();
        test_cmd_full();
        test_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/operand_queue_array.md
OPERAND_QUEUE_ARRAY -- requirements
Module: operand_queue_array

Interface
REQ-001 Parameter NrQueues, default 9, number of independent operand queues.
REQ-002 Parameter DataWidth, default 64, operand word width in bits.
REQ-003 Parameter Depth, default 4, data entries per queue; legal range 1..16.
REQ-004 Parameter CmdDepth, default 2, command entries per queue; legal range 1..4.
REQ-005 Parameter CntWidth, default 16, width of the element count carried by a command.
REQ-006 clk_i  in  1  single clock; reset is asynchronous and active-low.
REQ-007 rst_ni  in  1  asynchronous active-low reset.
REQ-008 operand_i  in  NrQueues x DataWidth  words returned by the VRF.
REQ-009 operand_valid_i  in  NrQueues  VRF word valid.
REQ-010 operand_issued_i  in  NrQueues  requester issued one VRF read; consumes one credit.
REQ-011 operand_queue_ready_o  out  NrQueues  a credit is available.
REQ-012 cmd_i  in  NrQueues x CntWidth  number of words the command delivers.
REQ-013 cmd_valid_i / cmd_ready_o  in / out  NrQueues  command handshake.
REQ-014 flush_i  in  NrQueues  discard queue contents.
REQ-015 operand_o  out  NrQueues x DataWidth  head word.
REQ-016 operand_valid_o / operand_ready_i  out / in  NrQueues  consumer handshake.
REQ-017 cmd_done_o  out  NrQueues  one-cycle pulse on command retirement.
REQ-018 stall_cnt_o  out  NrQueues x 32  consumer-stall cycle count.

Function
REQ-019 Queues SHALL be fully independent; all rules below apply per queue.
REQ-020 Credit rule: operand_queue_ready_o = (occupancy + outstanding + discard) < Depth, computed from registered state only.
REQ-021 operand_issued_i increments outstanding; operand_valid_i decrements it and pushes the word; when both occur in the same cycle the net outstanding change is zero.
REQ-022 operand_valid_i with outstanding = 0 and discard = 0 is illegal and SHALL be flagged by an assertion.
REQ-023 Latency: a word pushed in cycle t is visible on operand_o in cycle t+1 at the earliest; there is no combinational bypass.
REQ-024 operand_valid_o = data FIFO non-empty AND head command present AND head remaining > 0.
REQ-025 On an operand_valid_o && operand_ready_i handshake, the word pops and remaining decrements.
REQ-026 On the handshake that brings remaining to 0, the head command retires and cmd_done_o pulses in that same cycle; the next command becomes head in the following cycle.
REQ-027 A command with count 0 retires one cycle after reaching the head, with a cmd_done_o pulse and no data consumed.
REQ-028 cmd_ready_o = command FIFO not full.
REQ-029 Data and command FIFO pointers SHALL wrap modulo Depth and CmdDepth respectively; push and pop on a full or empty FIFO in the same cycle are both legal.
REQ-030 Flush: the data FIFO and command FIFO clear in the cycle after flush_i.
REQ-031 On flush, discard receives outstanding + issued - valid of the flush cycle, and outstanding becomes 0.
REQ-032 A word pushed in the flush cycle SHALL be dropped.
REQ-033 While discard > 0, arriving words SHALL be dropped and discard decremented.
REQ-034 A command accepted in the flush cycle SHALL be retained.
REQ-035 No cmd_done_o pulse SHALL be produced by a flush.

Reset
REQ-036 Asynchronous reset SHALL clear all pointers and counters, including when asserted mid-command.
REQ-037 Reset values: operand_valid_o=0, operand_o=0, cmd_done_o=0, operand_queue_ready_o=1, cmd_ready_o=1, stall_cnt_o=0.

Configuration
REQ-038 With OPQ_STALL_CNT_EN defined, each queue SHALL keep a 32-bit saturating counter of cycles with operand_valid_o && !operand_ready_i, driven on stall_cnt_o and cleared only by reset.
REQ-039 With OPQ_STALL_CNT_EN undefined, stall_cnt_o SHALL be tied to 0 and no counter logic SHALL exist.

Structure
REQ-040 Typedef opq_cmd_t (count field of CntWidth) and the limits MaxOpqDepth=16 and MaxOpqCmdDepth=4 SHALL reside in ara_pkg.
REQ-041 Each queue SHALL be one operand_queue_slice instance, replicated NrQueues times by a generate loop; the top level has no other logic.

Verification
REQ-042 Depth=4: 4 issues with no returns -> ready_o low on cycle 4; one return then one pop -> ready_o high again.
REQ-043 Command count 3, words A,B,C, consumer ready -> A,B,C out on consecutive cycles; cmd_done_o pulses with C.
REQ-044 Command count 0 followed by command count 1 -> cmd_done_o pulses twice; exactly one word consumed.
REQ-045 2 outstanding, flush, then 2 returns -> both returns dropped, operand_valid_o stays 0, ready_o = 1 after the second return.
REQ-046 Consumer held not-ready for 10 cycles with valid high -> stall_cnt_o = 10 with OPQ_STALL_CNT_EN defined, 0 without.
REQ-047 Reset asserted mid-command with 2 words buffered -> all outputs return to their reset values asynchronously.
